// File: rtl/rw_writeback_regfile.sv
// rw_writeback_regfile: RW stage write-back select, 16x32 register file with same-cycle read bypass.
// Optional retired-instruction counter enabled by defining RW_RETIRE_CNT_EN.
module rw_writeback_regfile #(
  parameter int          NREGS    = 16,
  parameter int          RA_IDX   = 15,
  parameter int          SP_IDX   = 14,
  parameter logic [31:0] SP_RESET = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_RW_PC,
  input  logic [31:0] input_RW_Ld_Result,
  input  logic [31:0] input_RW_ALU_Result,
  input  logic [31:0] input_RW_IR,
  input  logic [21:0] input_RW_controlBus,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retire_cnt
);
  localparam logic [3:0] RA = 4'(RA_IDX);
  logic        valid;
  logic        is_wb;
  logic        is_ld;
  logic        is_call;
  logic        unused_bits;
  logic [31:0] regs [NREGS];
  assign valid       = input_RW_controlBus[21];
  assign is_wb       = input_RW_controlBus[0];
  assign is_ld       = input_RW_controlBus[1];
  assign is_call     = input_RW_controlBus[2];
  assign unused_bits = ^{input_RW_controlBus[20:3], input_RW_IR[31:26], input_RW_IR[21:0]};
  // A bubble gates the write enable, so X payloads never reach the array.
  assign wb_en   = valid & is_wb;
  assign wb_addr = is_call ? RA : input_RW_IR[25:22];
  assign wb_data = is_call ? input_RW_PC + 32'd4 : is_ld ? input_RW_Ld_Result : input_RW_ALU_Result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? SP_RESET : 32'h0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end
  // Bypass is suppressed in reset so reads show the reset image.
  assign rd_data_a = (rst_n && wb_en && rd_addr_a == wb_addr) ? wb_data : regs[rd_addr_a];
  assign rd_data_b = (rst_n && wb_en && rd_addr_b == wb_addr) ? wb_data : regs[rd_addr_b];
`ifdef RW_RETIRE_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 32'h0;
    else if (valid) cnt <= cnt + 32'd1;
  end
  assign retire_cnt = cnt;
`else
  assign retire_cnt = 32'h0;
`endif
endmodule
